// File: rtl/t02_btn_event_queue.sv
// Button press event queue.
// Turns one-cycle press pulses from a bank of debouncers into button-index
// events held in a small first-word-fall-through FIFO. Each button owns a
// one-deep pending slot; a press that arrives while that button's previous
// press is still pending (and not leaving this cycle) is lost and raises a
// sticky overflow flag.
//
// Consumer handshake: evt_valid is the valid and rd_en is the ready. An
// entry is popped on a rising clk edge where evt_valid && rd_en; evt_code
// and evt_count are stable between edges. rd_en while evt_valid is low is
// ignored.
module t02_btn_event_queue #(
    parameter int NUM_BTN = 8,
    parameter int DEPTH   = 4,
    parameter int CODE_W  = 3,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_BTN-1:0] btn_pulse,
    input  logic               rd_en,
    input  logic               clr_ovf,
    output logic               evt_valid,
    output logic [CODE_W-1:0]  evt_code,
    output logic [CNT_W-1:0]   evt_count,
    output logic               overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] push_mask;
    logic [CODE_W-1:0]  sel;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CODE_W-1:0]  mem [DEPTH];
    logic               push;
    logic               pop;
    logic               lost;

    // Priority encoder: lowest-index pending button goes first.
    always_comb begin
        sel = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i]) sel = CODE_W'(i);
        end
    end

    // Push/pop decisions and lost-press detection. A full FIFO can still
    // accept a push when the head leaves in the same cycle.
    always_comb begin
        pop       = rd_en && (count != '0);
        push      = (|pending) && ((count < CNT_W'(DEPTH)) || pop);
        push_mask = push ? (NUM_BTN'(1) << sel) : '0;
        lost      = |(btn_pulse & pending & ~push_mask);
    end

    // Pending slots, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pending  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~push_mask) | btn_pulse;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // Setting wins over clearing so a loss is never hidden.
            if (lost)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // FIFO storage; contents after reset are don't-care, so no reset here.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sel;
    end

    // First-word-fall-through view of the head entry.
    always_comb begin
        evt_valid = (count != '0);
        evt_code  = evt_valid ? mem[rd_ptr] : '0;
        evt_count = count;
    end

endmodule

// File: tb/tb_t02_btn_event_queue.sv
// Testbench for the button press event queue.
module tb_t02_btn_event_queue;

    localparam int NUM_BTN = 8;
    localparam int DEPTH   = 4;
    localparam int CODE_W  = 3;
    localparam int CNT_W   = 3;

    logic               clk;
    logic               nrst;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               rd_en;
    logic               clr_ovf;
    logic               evt_valid;
    logic [CODE_W-1:0]  evt_code;
    logic [CNT_W-1:0]   evt_count;
    logic               overflow;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    t02_btn_event_queue #(
        .NUM_BTN(NUM_BTN),
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .btn_pulse(btn_pulse),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_count(evt_count),
        .overflow (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Queue of button codes in arrival order, a set of buttons waiting to
    // enter it, and the loss flag.
    logic [CODE_W-1:0] exp_q[$];
    bit                m_wait [NUM_BTN];
    bit                m_ovf;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_q.delete();
            foreach (m_wait[i]) m_wait[i] = 0;
            m_ovf = 0;
        end else begin
            bit do_pop, do_push, any_wait, any_lost;
            int first;
            do_pop   = rd_en && (exp_q.size() > 0);
            any_wait = 0;
            first    = -1;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (m_wait[i] && first < 0) first = i;
                if (m_wait[i]) any_wait = 1;
            end
            do_push  = any_wait && ((exp_q.size() < DEPTH) || do_pop);
            any_lost = 0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_pulse[i] && m_wait[i] && !(do_push && first == i))
                    any_lost = 1;
            end
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(CODE_W'(first));
                m_wait[first] = 0;
            end
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_pulse[i]) m_wait[i] = 1;
            end
            if (any_lost)     m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("sb_valid", int'(evt_valid), (exp_q.size() != 0) ? 1 : 0);
            chk("sb_count", int'(evt_count), exp_q.size());
            chk("sb_code",  int'(evt_code),  (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
            chk("sb_ovf",   int'(overflow),  int'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    // Apply inputs for one cycle; returns 1 time unit after the edge.
    task automatic step(input logic [NUM_BTN-1:0] p, input logic rd, input logic clr);
        @(negedge clk);
        btn_pulse = p;
        rd_en     = rd;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        nrst      = 1'b0;
        btn_pulse = '0;
        rd_en     = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst   = 1'b1;
        cmp_en = 1;

        // Reset then idle.
        idle(10);
        chk("idle_valid", int'(evt_valid), 0);
        chk("idle_count", int'(evt_count), 0);
        chk("idle_ovf",   int'(overflow),  0);
        chk("idle_code",  int'(evt_code),  0);

        // Single press of button 5: visible two cycles after the pulse.
        step(8'h20, 1'b0, 1'b0);
        chk("single_lat_valid", int'(evt_valid), 0);
        step('0, 1'b0, 1'b0);
        chk("single_valid", int'(evt_valid), 1);
        chk("single_code",  int'(evt_code),  5);
        chk("single_count", int'(evt_count), 1);
        step('0, 1'b1, 1'b0);
        chk("single_pop_valid", int'(evt_valid), 0);
        chk("single_pop_count", int'(evt_count), 0);

        // Simultaneous presses 1,4,7 drain in ascending order.
        step(8'h92, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("multi_cnt1", int'(evt_count), 1);
        step('0, 1'b0, 1'b0);
        chk("multi_cnt2", int'(evt_count), 2);
        step('0, 1'b0, 1'b0);
        chk("multi_cnt3", int'(evt_count), 3);
        chk("multi_head1", int'(evt_code), 1);
        step('0, 1'b1, 1'b0);
        chk("multi_head4", int'(evt_code), 4);
        step('0, 1'b1, 1'b0);
        chk("multi_head7", int'(evt_code), 7);
        step('0, 1'b1, 1'b0);
        chk("multi_empty", int'(evt_valid), 0);

        // Fill with 0..3, then press 6 twice while full.
        step(8'h0F, 1'b0, 1'b0);
        idle(4);
        chk("full_count", int'(evt_count), 4);
        step(8'h40, 1'b0, 1'b0);
        idle(2);
        chk("full_p1_count", int'(evt_count), 4);
        chk("full_p1_ovf",   int'(overflow),  0);
        step(8'h40, 1'b0, 1'b0);
        chk("full_p2_ovf", int'(overflow), 1);
        step('0, 1'b1, 1'b0);
        chk("full_pop_count", int'(evt_count), 4);
        chk("drain_1", int'(evt_code), 1);
        step('0, 1'b1, 1'b0);
        chk("drain_2", int'(evt_code), 2);
        step('0, 1'b1, 1'b0);
        chk("drain_3", int'(evt_code), 3);
        step('0, 1'b1, 1'b0);
        chk("drain_6", int'(evt_code), 6);
        step('0, 1'b1, 1'b0);
        chk("drain_empty", int'(evt_count), 0);
        chk("drain_ovf",   int'(overflow),  1);

        // Clear the sticky flag.
        step('0, 1'b0, 1'b1);
        chk("clr_ovf", int'(overflow), 0);

        // Streaming with reads held high; pointers wrap three times.
        for (int i = 0; i < 12; i++) begin
            logic [NUM_BTN-1:0] p;
            p = NUM_BTN'(1) << (i % NUM_BTN);
            step(p, 1'b1, 1'b0);
            step('0, 1'b1, 1'b0);
            chk("stream_code", int'(evt_code), i % NUM_BTN);
            chk("stream_count", int'(evt_count), 1);
        end
        step('0, 1'b1, 1'b0);
        chk("stream_end_count", int'(evt_count), 0);
        chk("stream_ovf", int'(overflow), 0);

        // Reset mid-drain with queued and pending presses.
        step(8'h0F, 1'b0, 1'b0);
        idle(3);
        chk("rst_pre_count", int'(evt_count), 3);
        step('0, 1'b1, 1'b0);
        chk("rst_mid_count", int'(evt_count), 3);
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_count", int'(evt_count), 0);
        chk("rst_code",  int'(evt_code),  0);
        chk("rst_ovf",   int'(overflow),  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        idle(5);
        chk("post_rst_valid", int'(evt_valid), 0);
        chk("post_rst_count", int'(evt_count), 0);

        // ---------------- final report ----------------
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t02_btn_event_queue.md
Name: t02_btn_event_queue

Overview:
Collects one-cycle press pulses from a bank of per-button debouncers and encodes each press as a button index. Presses are queued in a small first-word-fall-through FIFO so downstream game/control logic can consume them at its own pace. No press is dropped silently: each button has a one-deep pending slot, and any lost press sets a sticky overflow flag.

Parameters:
NUM_BTN, 8, number of debounced button pulse inputs (2..16)
DEPTH, 4, FIFO entries; power of 2, >= 2
CODE_W, 3, width of encoded button index; must satisfy 2**CODE_W >= NUM_BTN
CNT_W, 3, occupancy width = log2(DEPTH)+1

Ports:
clk  input  1  system clock (12 MHz)
nrst  input  1  asynchronous active-low reset
btn_pulse  input  NUM_BTN  one-cycle press pulses; bit i comes from debouncer i
rd_en  input  1  consumer pops the head entry this cycle
clr_ovf  input  1  synchronous clear of the overflow flag
evt_valid  output  1  FIFO non-empty; evt_code is valid
evt_code  output  CODE_W  button index at the FIFO head
evt_count  output  CNT_W  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky; at least one press was lost since the last clear

Behaviour:
- Reset (nrst=0, asynchronous):
  - pending=0, rd_ptr=wr_ptr=0, count=0, overflow=0.
  - Outputs: evt_valid=0, evt_code=0, evt_count=0.
  - FIFO storage contents are don't-care.
- Pending register (NUM_BTN bits), per cycle:
  - sel = lowest-index set bit of pending.
  - push = (pending != 0) && (count < DEPTH || pop).
  - pop = rd_en && (count != 0).
  - pending_next = (pending & ~(push ? onehot(sel) : 0)) | btn_pulse.
- Lost press: btn_pulse[i]=1 while pending[i]=1 and bit i is not pushed this cycle.
  - The press merges into the existing pending bit and sets overflow=1 at the next edge.
  - A pulse on the same bit that is pushed this cycle is not lost; the bit stays set.
- Push: mem[wr_ptr] <= sel; wr_ptr increments. Pointers are log2(DEPTH) bits and wrap naturally.
- Pop: rd_ptr increments. rd_en while empty is ignored: no pointer change, no error.
- Count update:
  - count += push - pop.
  - Simultaneous push and pop while full is legal; count stays DEPTH.
  - Simultaneous push and pop while empty cannot occur, because pop requires count != 0.
- FWFT outputs (combinational from registers):
  - evt_valid = (count != 0).
  - evt_code = mem[rd_ptr] when evt_valid, else 0.
  - evt_count = count.
- Latency: a pulse at edge k sets pending; it is pushed at edge k+1 (FIFO not full); evt_valid rises after edge k+1. Pulse to visible event is 2 cycles.
- Simultaneous pulses on several buttons in one cycle:
  - All are captured in pending.
  - They drain one per cycle in ascending index order.
- FIFO full with pops stalled:
  - Pending holds; one further press per button is absorbed.
  - Loss occurs only on a second press of a button that is still pending.
- overflow:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf=1 clears it at the next edge.
- Reset mid-operation: everything is discarded, including pending presses and queued entries; overflow clears.
- btn_pulse bits beyond the codable range do not exist, since NUM_BTN <= 2**CODE_W.

Test Plan:
- Reset then idle 10 cycles -> evt_valid=0, evt_count=0, overflow=0, evt_code=0.
- Single pulse btn_pulse=8'h20 at edge k -> evt_valid=1 and evt_code=5 after edge k+1, evt_count=1; rd_en for one cycle -> evt_valid=0, evt_count=0.
- Simultaneous pulse btn_pulse=8'h92, no reads -> FIFO fills with codes 1,4,7 on consecutive cycles; evt_count 1,2,3; popping returns 1, 4, 7 in order.
- Fill to DEPTH=4 (buttons 0,1,2,3), then pulse button 6 twice, 3 cycles apart, without reads:
  - After the first pulse: count=4, pending[6]=1, overflow=0.
  - After the second pulse: overflow=1.
  - One pop: button 6 is pushed the same cycle; count stays 4.
  - Drain: codes 1,2,3,6.
- Push-pop concurrency and wrap:
  - Stream 12 single presses (one every 2 cycles) while rd_en is held high.
  - Codes come out in order; pointers wrap 3 times; evt_count never exceeds 1; overflow=0.
- overflow=1 with clr_ovf pulsed -> overflow=0.
- Assert nrst low mid-drain with evt_count=3 and pending!=0 -> outputs zero immediately; no stale event appears after reset release.
